// File: rtl/ptc_seq_ctrl.sv
// ptc_seq_ctrl: PWM duty-cycle table sequencer driving the PTC write port; PTC_SEQ_IRQ_EN builds the sticky irq
module ptc_seq_ctrl #(
  parameter int CW = 16,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_idx,
  input  logic [CW-1:0] tbl_hrc,
  input  logic [CW-1:0] tbl_lrc,
  input  logic [IW-1:0] seq_len,
  input  logic          seq_loop,
  input  logic          seq_pol,
  input  logic          start,
  input  logic          stop,
  input  logic          period_end,
  output logic [5:0]    ptc_addr,
  output logic [31:0]   ptc_wdata,
  output logic [1:0]    ptc_wr_n,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] cur_idx,
  output logic          overrun,
  output logic          irq
);
  typedef enum logic [2:0] {IDLE, W_CLR, W_HRC, W_LRC, W_EN, RUN, W_OFF} state_t;
  localparam logic [IW-1:0] ONE = 1;
  state_t state, state_n, nrm;
  logic [CW-1:0] hrc_t [2**IW];
  logic [CW-1:0] lrc_t [2**IW];
  logic [IW-1:0] idx_n;
  logic upd, upd_n, pend, pend_n, ov_n, wr, go;
  logic [4:0] a_n;
  logic [31:0] d_n;
  assign go = state == IDLE && start && !stop;
  always_comb begin
    nrm = state;
    idx_n = cur_idx;
    upd_n = upd;
    ov_n = overrun;
    pend_n = pend;
    case (state)
      IDLE:  if (go) begin
               nrm = W_CLR;
               idx_n = '0;
               ov_n = 1'b0;
               upd_n = 1'b0;
               pend_n = 1'b0;
             end
      W_CLR: nrm = W_HRC;
      W_HRC: nrm = W_LRC;
      W_LRC: nrm = upd ? RUN : W_EN;
      W_EN:  nrm = RUN;
      RUN:   if (stop) nrm = W_OFF;
             else if (period_end) begin
               nrm = (cur_idx != seq_len || seq_loop) ? W_HRC : W_OFF;
               idx_n = cur_idx != seq_len ? cur_idx + ONE : (seq_loop ? '0 : cur_idx);
               upd_n = 1'b1;
             end
      W_OFF: nrm = IDLE;
      default: nrm = IDLE;
    endcase
    if ((state == W_HRC || state == W_LRC) && upd && period_end) ov_n = 1'b1;
    state_n = nrm;
    // a stop inside a write burst lets the write in flight land, then shuts down
    if (state inside {W_CLR, W_HRC, W_LRC, W_EN}) begin
      if (pend || (stop && nrm == RUN)) state_n = W_OFF;
      else if (stop) pend_n = 1'b1;
    end
    wr = state_n != IDLE && state_n != RUN;
    a_n = state_n == W_HRC ? 5'h04 : state_n == W_LRC ? 5'h08 : 5'h0C;
    d_n = state_n == W_HRC ? 32'(hrc_t[idx_n]) :
          state_n == W_LRC ? 32'(lrc_t[idx_n]) :
          state_n == W_CLR ? 32'h080 :
          state_n == W_EN  ? 32'h009 : 32'h000;
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 2**IW; i++) begin
        hrc_t[i] <= '0;
        lrc_t[i] <= '0;
      end
    end else if (tbl_we) begin
      hrc_t[tbl_idx] <= tbl_hrc;
      lrc_t[tbl_idx] <= tbl_lrc;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      upd <= 1'b0;
      pend <= 1'b0;
      ptc_addr <= '0;
      ptc_wdata <= '0;
      ptc_wr_n <= 2'b11;
      busy <= 1'b0;
      done <= 1'b0;
      cur_idx <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      upd <= upd_n;
      pend <= pend_n;
      ptc_addr <= wr ? {seq_pol, a_n} : 6'd0;
      ptc_wdata <= wr ? d_n : 32'd0;
      ptc_wr_n <= wr ? 2'b10 : 2'b11;
      busy <= state_n != IDLE;
      done <= state_n == W_OFF;
      cur_idx <= idx_n;
      overrun <= ov_n;
    end
`ifdef PTC_SEQ_IRQ_EN
  always_ff @(posedge clk)
    if (rst || go) irq <= 1'b0;
    else if (state_n == W_OFF || (ov_n && !overrun)) irq <= 1'b1;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_ptc_seq_ctrl.sv
// tb_ptc_seq_ctrl: directed bench with a write scoreboard for ptc_seq_ctrl
module tb_ptc_seq_ctrl;
  logic clk = 0, rst = 1, tbl_we = 0, seq_loop = 0, seq_pol = 0, start = 0, stop = 0, period_end = 0;
  logic [2:0] tbl_idx = 0, seq_len = 0;
  logic [15:0] tbl_hrc = 0, tbl_lrc = 0;
  logic [5:0] ptc_addr;
  logic [31:0] ptc_wdata;
  logic [1:0] ptc_wr_n;
  logic busy, done, overrun, irq, mon_en = 0, irq_exp;
  logic [2:0] cur_idx;
  logic [37:0] q[$];
  logic [37:0] e;
  int total = 0, bad = 0;
  ptc_seq_ctrl dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_hrc(tbl_hrc), .tbl_lrc(tbl_lrc),
    .seq_len(seq_len), .seq_loop(seq_loop), .seq_pol(seq_pol), .start(start), .stop(stop),
    .period_end(period_end), .ptc_addr(ptc_addr), .ptc_wdata(ptc_wdata), .ptc_wr_n(ptc_wr_n),
    .busy(busy), .done(done), .cur_idx(cur_idx), .overrun(overrun), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [4:0] a, input logic [31:0] d);
    q.push_back({seq_pol, a, d});
  endtask
  task automatic push_start(input logic [31:0] h, input logic [31:0] l);
    push(5'h0C, 32'h080);
    push(5'h04, h);
    push(5'h08, l);
    push(5'h0C, 32'h009);
  endtask
  task automatic wr_tbl(input logic [2:0] i, input logic [15:0] h, input logic [15:0] l);
    tbl_we = 1; tbl_idx = i; tbl_hrc = h; tbl_lrc = l;
    tick();
    tbl_we = 0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_wr_n"}, ptc_wr_n, 2'b11);
    chk({tag, "_addr"}, ptc_addr, 0);
    chk({tag, "_wdata"}, ptc_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_idx"}, cur_idx, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask
  always @(negedge clk)
    if (mon_en) begin
      if (ptc_wr_n == 2'b10 && q.size() > 0) begin
        e = q.pop_front();
        chk("wr_addr", ptc_addr, e[37:32]);
        chk("wr_data", ptc_wdata, e[31:0]);
      end else chk("wr_n", ptc_wr_n, 2'b11);
    end
  initial begin
    tick();
    tick();
    chk_reset("rst");
    rst = 0;
    mon_en = 1;
    wr_tbl(0, 10, 20);
    wr_tbl(1, 5, 30);
    seq_len = 1;
    // single pass
    push_start(10, 20);
    start = 1;
    tick();
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_idx", cur_idx, 0);
    repeat (4) tick();
    chk("run_wrq", q.size(), 0);
    repeat (2) tick();
    push(5'h04, 5);
    push(5'h08, 30);
    period_end = 1;
    tick();
    period_end = 0;
    chk("pe1_idx", cur_idx, 1);
    repeat (4) tick();
    push(5'h0C, 0);
    period_end = 1;
    tick();
    period_end = 0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 1);
    tick();
    chk("end_done_clr", done, 0);
    chk("end_idle", busy, 0);
    tick();
    // looping
    seq_loop = 1;
    push_start(10, 20);
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      push(5'h04, k == 1 ? 10 : 5);
      push(5'h08, k == 1 ? 20 : 30);
      period_end = 1;
      tick();
      period_end = 0;
      chk("loop_idx", cur_idx, k == 1 ? 0 : 1);
      tick();
      tick();
      chk("loop_nodone", done, 0);
    end
    chk("loop_ovr", overrun, 0);
    push(5'h0C, 0);
    stop = 1;
    tick();
    stop = 0;
    chk("stop_run_done", done, 1);
    tick();
    chk("stop_run_idle", busy, 0);
    // polarity and stop inside the start-up burst
    seq_pol = 1;
    seq_loop = 0;
    push(5'h0C, 32'h080);
    push(5'h04, 10);
    push(5'h08, 20);
    push(5'h0C, 0);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("pol_hrc_addr", ptc_addr, 6'h24);
    stop = 1;
    tick();
    stop = 0;
    chk("stop_lrc_addr", ptc_addr, 6'h28);
    tick();
    chk("stop_w_done", done, 1);
    chk("stop_w_addr", ptc_addr, 6'h2C);
    tick();
    chk("stop_w_idle", busy, 0);
    // overrun with pulses two cycles apart
    seq_pol = 0;
    seq_loop = 1;
    push_start(10, 20);
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    push(5'h04, 5);
    push(5'h08, 30);
    period_end = 1;
    tick();
    period_end = 0;
    tick();
    period_end = 1;
    tick();
    period_end = 0;
    `ifdef PTC_SEQ_IRQ_EN
    irq_exp = 1;
    `else
    irq_exp = 0;
    `endif
    chk("ovr_set", overrun, 1);
    chk("ovr_idx", cur_idx, 1);
    chk("ovr_irq", irq, irq_exp);
    push(5'h0C, 0);
    stop = 1;
    tick();
    stop = 0;
    tick();
    chk("ovr_sticky", overrun, 1);
    chk("ovr_irq_hold", irq, irq_exp);
    push_start(10, 20);
    start = 1;
    tick();
    start = 0;
    chk("ovr_clr", overrun, 0);
    chk("irq_clr", irq, 0);
    repeat (5) tick();
    // reset while running
    rst = 1;
    tick();
    rst = 0;
    chk_reset("mid_rst");
    repeat (3) tick();
    chk("final_wrq", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
